readback_tx: RTL and testbench

Return path for register reads issued through the command decoder. On a read strobe (RCLK edge qualified by one-hot RE), captures the selected DATAWIDTH-bit register value and shifts it MSB-first onto MISO during the host's next SPI mode-0 frame. Sits between the register bank outputs and the SPI pin pad. SCK and CS_N are asynchronous to clk and are resynchronised internally.

---
 rtl/readback_tx.sv | 148 ++++++++++++++
 tb/tb_readback_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/readback_tx.sv
// Register readback serializer: captures the RE-selected word on an RCLK edge and shifts it MSB-first onto MISO in the next SPI mode-0 frame.
// Latency: BUSY one clk after the strobe; MISO bits follow SCK after SYNC_STAGES+1 clks. Requests during a frame are dropped and flagged in ERR[1].
// Define READBACK_PARITY_EN to append an even-parity bit to each frame.
module readback_tx #(
  parameter int NUM_REGS    = 8,
  parameter int DATAWIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REGS-1:0]           RE,
  input  logic                          RCLK,
  input  logic [NUM_REGS*DATAWIDTH-1:0] RDATA_IN,
  input  logic                          SCK,
  input  logic                          CS_N,
  input  logic                          ERR_CLR,
  output logic                          MISO,
  output logic                          BUSY,
  output logic                          TX_DONE,
  output logic [1:0]                    ERR
);

`ifdef READBACK_PARITY_EN
  localparam int FRAME_LEN = DATAWIDTH + 1;
`else
  localparam int FRAME_LEN = DATAWIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_q;
  logic                   cs_q;
  logic                   rclk_q;
  logic [DATAWIDTH-1:0]   cap_reg;
  logic [FRAME_LEN-1:0]   sh_reg;
  logic [CNT_W-1:0]       bit_cnt;

  logic                   sck_s;
  logic                   cs_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_fall;
  logic                   req;
  logic                   multi_hot;
  logic [DATAWIDTH-1:0]   sel_data;
  logic [1:0]             err_set;

  function automatic logic [FRAME_LEN-1:0] frame_of(input logic [DATAWIDTH-1:0] d);
`ifdef READBACK_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign cs_fall  = ~cs_s & cs_q;

  assign req       = RCLK & ~rclk_q & (|RE);
  assign multi_hot = |(RE & (RE - NUM_REGS'(1)));

  // Scan downward so the lowest set RE bit wins.
  always_comb begin
    sel_data = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (RE[i]) sel_data = RDATA_IN[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  assign err_set[0] = req & multi_hot;
  assign err_set[1] = req & ((state == ST_SHIFT) | (state == ST_DONE));

  assign MISO    = ((state == ST_ARMED) | (state == ST_SHIFT)) & ~cs_s & sh_reg[FRAME_LEN-1];
  assign BUSY    = (state != ST_IDLE);
  assign TX_DONE = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sck_sync <= '0;
      cs_sync  <= '0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b0;
      rclk_q   <= 1'b0;
      cap_reg  <= '0;
      sh_reg   <= '0;
      bit_cnt  <= '0;
      ERR      <= 2'b00;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS_N};
      sck_q    <= sck_s;
      cs_q     <= cs_s;
      rclk_q   <= RCLK;
      // A set event in the same cycle as ERR_CLR keeps the bit set.
      ERR      <= (ERR & {2{~ERR_CLR}}) | err_set;

      case (state)
        ST_IDLE: begin
          if (req) begin
            cap_reg <= sel_data;
            sh_reg  <= frame_of(sel_data);
            state   <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (req) begin
            cap_reg <= sel_data;
            sh_reg  <= frame_of(sel_data);
          end
          if (cs_fall) begin
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Host deselected early: rewind so a retry resends from the MSB.
          if (cs_s) begin
            sh_reg <= frame_of(cap_reg);
            state  <= ST_ARMED;
          end else if (sck_rise) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(FRAME_LEN - 1)) state <= ST_DONE;
          end else if (sck_fall) begin
            sh_reg <= {sh_reg[FRAME_LEN-2:0], 1'b0};
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readback_tx.sv
// Bench for readback_tx: table of readback words plus hand sequences for abort, drop, replace and reset.
module tb_readback_tx;

  localparam int NR = 8;
  localparam int DW = 16;
`ifdef READBACK_PARITY_EN
  localparam int FRAME = DW + 1;
`else
  localparam int FRAME = DW;
`endif

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    re;
  logic             rclk;
  logic [NR*DW-1:0] rdata;
  logic             sck;
  logic             cs_n;
  logic             err_clr;
  logic             miso;
  logic             busy;
  logic             tx_done;
  logic [1:0]       err;

  readback_tx #(.NUM_REGS(NR), .DATAWIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .RE(re), .RCLK(rclk), .RDATA_IN(rdata),
    .SCK(sck), .CS_N(cs_n), .ERR_CLR(err_clr),
    .MISO(miso), .BUSY(busy), .TX_DONE(tx_done), .ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int dbl_cnt = 0;
  logic done_prev = 1'b0;
  logic [31:0] sb[$];

  always @(negedge clk) begin
    if (tx_done && done_prev) dbl_cnt++;
    if (tx_done) done_cnt++;
    done_prev = tx_done;
  end

  typedef struct {
    logic [7:0]  re;
    int          idx;
    logic [15:0] d;
    logic [1:0]  err;
  } vec_t;

  function automatic logic [31:0] exp_frame(input logic [15:0] d);
`ifdef READBACK_PARITY_EN
    return {15'b0, d, ^d};
`else
    return {16'b0, d};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_regs(input int idx, input logic [15:0] d);
    for (int i = 0; i < NR; i++) rdata[i*DW +: DW] = (i == idx) ? d : ~d;
  endtask

  task automatic req(input logic [7:0] r, input logic clr);
    re = r; rclk = 1'b1; err_clr = clr;
    wait_clk(1);
    rclk = 1'b0; err_clr = 1'b0;
    wait_clk(1);
  endtask

  task automatic sck_bit(output logic b);
    sck = 1'b1;
    b = miso;
    wait_clk(8);
    sck = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic rx_score(input string name);
    logic [31:0] w;
    logic [31:0] e;
    logic b;
    w = '0;
    cs_low();
    for (int i = 0; i < FRAME; i++) begin
      sck_bit(b);
      w = {w[30:0], b};
    end
    cs_high();
    chk({name, "_sb_depth"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(name, w, e);
    end
  endtask

  vec_t vt[6];

  initial begin
    logic [31:0] w;
    logic b;
    int d0;

    vt[0] = '{8'h02, 1, 16'hA4A4, 2'b00};
    vt[1] = '{8'h05, 0, 16'h1234, 2'b01};
    vt[2] = '{8'h80, 7, 16'h8001, 2'b00};
    vt[3] = '{8'h0C, 2, 16'h7E81, 2'b01};
    vt[4] = '{8'h01, 0, 16'h0001, 2'b00};
    vt[5] = '{8'h10, 4, 16'h5A5A, 2'b00};

    rst_n = 1'b0; re = '0; rclk = 1'b0; rdata = '0;
    sck = 1'b0; cs_n = 1'b1; err_clr = 1'b0;
    wait_clk(3);
    chk("rst_miso", miso, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txdone", tx_done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    wait_clk(4);

    // Strobe with no RE bit set must be ignored.
    req(8'h00, 1'b0);
    chk("re0_busy", busy, 0);
    chk("re0_err", err, 0);

    for (int v = 0; v < 6; v++) begin
      set_regs(vt[v].idx, vt[v].d);
      req(vt[v].re, 1'b0);
      chk("vec_busy_armed", busy, 1);
      chk("vec_miso_cs_high", miso, 0);
      chk("vec_err_req", err, {30'b0, vt[v].err});
      sb.push_back(exp_frame(vt[v].d));
      d0 = done_cnt;
      rx_score("vec_frame");
      chk("vec_txdone_cnt", done_cnt - d0, 1);
      chk("vec_busy_after", busy, 0);
      chk("vec_err_after", err, {30'b0, vt[v].err});
      if (vt[v].err != 2'b00) begin
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        chk("vec_err_clr", err, 0);
      end
    end

    // Early CS_N release after 5 bits, then a full retry.
    set_regs(3, 16'hCA33);
    req(8'h08, 1'b0);
    sb.push_back(exp_frame(16'hCA33));
    d0 = done_cnt;
    w = '0;
    cs_low();
    for (int i = 0; i < 5; i++) begin
      sck_bit(b);
      w = {w[30:0], b};
    end
    cs_high();
    chk("abort_partial", w, 32'(16'hCA33 >> 11));
    chk("abort_busy", busy, 1);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_err", err, 0);
    rx_score("abort_retry");
    chk("abort_done_cnt", done_cnt - d0, 1);

    // Request mid-frame is dropped; frame carries original word.
    set_regs(5, 16'h3C96);
    req(8'h20, 1'b0);
    sb.push_back(exp_frame(16'h3C96));
    d0 = done_cnt;
    w = '0;
    cs_low();
    for (int i = 0; i < 8; i++) begin
      sck_bit(b);
      w = {w[30:0], b};
    end
    rdata[15:0] = 16'hFFFF;
    req(8'h01, 1'b0);
    chk("drop_err", err, 2'b10);
    for (int i = 8; i < FRAME; i++) begin
      sck_bit(b);
      w = {w[30:0], b};
    end
    cs_high();
    chk("drop_sb_depth", sb.size(), 1);
    if (sb.size() != 0) chk("drop_frame", w, sb.pop_front());
    chk("drop_done_cnt", done_cnt - d0, 1);
    chk("drop_busy", busy, 0);
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;

    // Re-request while armed replaces the word; ERR_CLR with a set event keeps the bit.
    set_regs(1, 16'hAAAA);
    req(8'h02, 1'b0);
    sb.push_back(exp_frame(16'hAAAA));
    set_regs(3, 16'h5555);
    req(8'h18, 1'b1);
    void'(sb.pop_back());
    sb.push_back(exp_frame(16'h5555));
    chk("replace_err_setclr", err, 2'b01);
    rx_score("replace_frame");
    chk("replace_busy", busy, 0);
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    chk("replace_err_clr", err, 0);

    // Reset during SHIFT aborts silently.
    set_regs(5, 16'hF00F);
    req(8'h60, 1'b0);
    chk("rstmid_err_pre", err, 2'b01);
    d0 = done_cnt;
    cs_low();
    for (int i = 0; i < 4; i++) sck_bit(b);
    rst_n = 1'b0;
    wait_clk(1);
    chk("rstmid_miso", miso, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_err", err, 0);
    rst_n = 1'b1;
    cs_high();
    chk("rstmid_no_done", done_cnt - d0, 0);
    set_regs(5, 16'hF00F);
    req(8'h20, 1'b0);
    sb.push_back(exp_frame(16'hF00F));
    rx_score("rstmid_after");
    chk("rstmid_after_done", done_cnt - d0, 1);
    chk("rstmid_after_busy", busy, 0);

    chk("txdone_single_pulse", dbl_cnt, 0);
    chk("sb_empty_end", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
